// File: rtl/wishbone_sram_slave_if.sv
// Wishbone bus bundle shared by masters and the SRAM responder.
// width codes: 2'd0 byte, 2'd1 half-word, 2'd2 word, 2'd3 reserved.
interface WISHBONE_IF #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic iClk,
    input logic iRst
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_write;
    logic [DATA_WIDTH-1:0] data_read;
    logic                  we;
    logic                  stb;
    logic                  cyc;
    logic [1:0]            width;
    logic                  ack;

    modport slave (
        input  iClk, iRst, addr, data_write, we, stb, cyc, width,
        output ack, data_read
    );

    modport master (
        input  iClk, iRst, ack, data_read,
        output addr, data_write, we, stb, cyc, width
    );
endinterface

// File: rtl/wishbone_sram_slave.sv
// Wishbone responder in front of a word-organised RAM. Little-endian byte,
// half-word and word accesses, configurable base address and wait states.
// Optional feature macro: WB_SRAM_ALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses are acked without effect and flagged on oMisalign.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for cyc & stb
// WAIT   | counting down wait states; request must stay asserted
// ACK    | ack high for this single cycle, then back to IDLE
module wishbone_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic      iClk,
    input  logic      iRst,
    WISHBONE_IF.slave bus,
    output logic      oMisalign
);

    localparam int         IDX_W         = $clog2(DEPTH);
    localparam logic [1:0] DW_B          = 2'd0;
    localparam logic [1:0] DW_H          = 2'd1;
    localparam logic [1:0] DW_W          = 2'd2;
    localparam logic [3:0] WAIT_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("wishbone_sram_slave: DATA_WIDTH must be 32");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("wishbone_sram_slave: DEPTH must be a power of two >= 2");
        end
        if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
            $error("wishbone_sram_slave: BASE_ADDR must be 4-byte aligned");
        end
        if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait
            $error("wishbone_sram_slave: WAIT_STATES must be 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  req;
    logic                  misalign;
    logic                  valid_acc;
    logic                  enter_ack;
    logic                  do_write;
    logic [31:0]           word_rd;
    logic [31:0]           rd_val;
    logic [3:0]            be;
    logic [31:0]           wdata;

    assign off      = bus.addr - BASE_ADDR;
    assign idx      = off[IDX_W+1:2];
    assign lane     = off[1:0];
    assign in_range = (bus.addr >= BASE_ADDR) && (off[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign req      = bus.cyc & bus.stb;

`ifdef WB_SRAM_ALIGN_CHECK_EN
    assign misalign = ((bus.width == DW_H) && off[0]) ||
                      ((bus.width == DW_W) && (off[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // An access only touches the RAM when it decodes, has a legal width and is aligned.
    assign valid_acc = in_range && (bus.width != 2'b11) && !misalign;

    // The commit edge is the one that moves the FSM into ACK.
    assign enter_ack = !iRst && req &&
                       (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                        ((state == S_WAIT) && (wait_cnt == 4'd0)));
    assign do_write  = enter_ack && bus.we && valid_acc;
    assign word_rd   = mem[idx];

    // Right-justified, zero-extended read data for the addressed lane(s).
    always_comb begin
        rd_val = '0;
        if (valid_acc) begin
            case (bus.width)
                DW_B:    rd_val = {24'b0, word_rd[{lane, 3'b000} +: 8]};
                DW_H:    rd_val = {16'b0, (off[1] ? word_rd[31:16] : word_rd[15:0])};
                DW_W:    rd_val = word_rd;
                default: rd_val = '0;
            endcase
        end
    end

    // Byte enables and write data replicated onto every candidate lane.
    always_comb begin
        be    = 4'b0000;
        wdata = bus.data_write;
        case (bus.width)
            DW_B: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.data_write[7:0]}};
            end
            DW_H: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.data_write[15:0]}};
            end
            DW_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge iClk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef WB_SRAM_ALIGN_CHECK_EN
    logic misalign_q;
    assign oMisalign = misalign_q;
`else
    assign oMisalign = 1'b0;
`endif

    // Transfer FSM with registered ack, read data and misalign flag.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state         <= S_IDLE;
            wait_cnt      <= 4'd0;
            bus.ack       <= 1'b0;
            bus.data_read <= '0;
`ifdef WB_SRAM_ALIGN_CHECK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            bus.ack <= enter_ack;
`ifdef WB_SRAM_ALIGN_CHECK_EN
            misalign_q <= enter_ack && misalign;
`endif
            if (enter_ack && !bus.we) begin
                bus.data_read <= rd_val;
            end
            case (state)
                S_IDLE: begin
                    if (enter_ack) begin
                        state <= S_ACK;
                    end else if (req) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
